// File: rtl/fsmc_pkg.sv
// rtl/fsmc_pkg.sv - shared types and defaults for the FSMC slot scheduler
package fsmc_pkg;

    localparam int          FSMC_CS_WIDTH        = 2;
    localparam int          FSMC_TIMEOUT_CYCLES  = 15;
    localparam logic [15:0] FSMC_DEFAULT_RD_DATA = 16'hDEAD;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_REQ = 3'd1,
        ST_HOLD   = 3'd2,
        ST_WR_ARM = 3'd3,
        ST_WR_REQ = 3'd4
    } fsmc_state_t;

    // Start event captured while a write request is still running.
    typedef struct packed {
        logic                     valid;
        logic                     is_read;
        logic [FSMC_CS_WIDTH-1:0] slot;
    } fsmc_pending_t;

endpackage

// File: rtl/fsmc_timeout_ctr.sv
// rtl/fsmc_timeout_ctr.sv - request-cycle counter flagging the last allowed cycle
// Ports: clk, reset (async, active-high), clear (restart at 0),
//        enable (count this cycle), expired (current cycle is cycle LIMIT).
module fsmc_timeout_ctr #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    // The count starts at 0 on the first request cycle, so LIMIT-1 marks the
    // LIMIT-th cycle; the request ends on that cycle's edge if no ack arrives.
    assign expired = (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/fsmc_slot_scheduler.sv
// rtl/fsmc_slot_scheduler.sv - routes FSMC bridge transactions to one-hot peripheral slots
// Ports: clk, reset (async, active-high)
//        bus_cs/bus_state/bus_data in, bus_rd_data out   : FSMC bridge side
//        slot_req/slot_we/slot_wdata out, slot_rdata/slot_ack in : slot side
//        busy, err_pulse, err_count out                  : status
module fsmc_slot_scheduler
    import fsmc_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 16,
    parameter int                    CS_WIDTH        = FSMC_CS_WIDTH,
    parameter int                    NUM_SLOTS       = 2 ** CS_WIDTH,
    parameter int                    TIMEOUT_CYCLES  = FSMC_TIMEOUT_CYCLES,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_RD_DATA = DATA_WIDTH'(FSMC_DEFAULT_RD_DATA)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_SLOTS-1:0]            bus_cs,
    input  logic                            bus_state,
    input  logic [DATA_WIDTH-1:0]           bus_data,
    output logic [DATA_WIDTH-1:0]           bus_rd_data,
    output logic [NUM_SLOTS-1:0]            slot_req,
    output logic                            slot_we,
    output logic [DATA_WIDTH-1:0]           slot_wdata,
    input  logic [NUM_SLOTS*DATA_WIDTH-1:0] slot_rdata,
    input  logic [NUM_SLOTS-1:0]            slot_ack,
    output logic                            busy,
    output logic                            err_pulse,
    output logic [7:0]                      err_count
);

    fsmc_state_t         state, state_nx;
    fsmc_pending_t       pend;
    logic [NUM_SLOTS-1:0] prev_cs;
    logic [CS_WIDTH-1:0] slot_idx, cs_idx, slot_load_val;
    logic [DATA_WIDTH-1:0] rdata_arr [NUM_SLOTS];
    logic start_evt, start_ok, start_bad, cs_idle, ack_sel;
    logic to_expired, to_clear, to_enable;
    logic slot_load, pend_store, pend_clear, err_evt;

    always_comb begin
        cs_idx = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus_cs[i]) cs_idx = CS_WIDTH'(i);
            rdata_arr[i] = slot_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A start is the first cycle of a nonzero select after an idle select.
    assign start_evt = (prev_cs == '0) && (bus_cs != '0);
    assign start_ok  = start_evt && $onehot(bus_cs);
    assign start_bad = start_evt && !$onehot(bus_cs);
    assign cs_idle   = (bus_cs == '0);
    assign ack_sel   = slot_ack[slot_idx];

    fsmc_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (to_clear),
        .enable  (to_enable),
        .expired (to_expired)
    );

    assign to_enable = (state == ST_RD_REQ) || (state == ST_WR_REQ);
    assign to_clear  = ((state_nx == ST_RD_REQ) || (state_nx == ST_WR_REQ)) && (state_nx != state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        slot_load     = 1'b0;
        slot_load_val = cs_idx;
        pend_store    = 1'b0;
        pend_clear    = 1'b0;
        err_evt       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nx  = bus_state ? ST_RD_REQ : ST_WR_ARM;
                    slot_load = 1'b1;
                end else if (start_bad) begin
                    err_evt = 1'b1;
                end
            end
            ST_RD_REQ: begin
                // Ack beats both abort and timeout on the same cycle.
                if (ack_sel) begin
                    state_nx = ST_HOLD;
                end else if (cs_idle) begin
                    state_nx = ST_IDLE;
                    err_evt  = 1'b1;
                end else if (to_expired) begin
                    state_nx = ST_HOLD;
                    err_evt  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cs_idle) state_nx = ST_IDLE;
            end
            ST_WR_ARM: begin
                if (cs_idle) state_nx = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                if (!ack_sel && to_expired) err_evt = 1'b1;
                if (start_bad || (start_ok && pend.valid)) err_evt = 1'b1;
                if (ack_sel || to_expired) begin
                    // Chain straight into the queued transaction, skipping IDLE.
                    if (pend.valid) begin
                        state_nx      = pend.is_read ? ST_RD_REQ : ST_WR_ARM;
                        slot_load     = 1'b1;
                        slot_load_val = CS_WIDTH'(pend.slot);
                        pend_clear    = 1'b1;
                    end else if (start_ok) begin
                        state_nx  = bus_state ? ST_RD_REQ : ST_WR_ARM;
                        slot_load = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else if (start_ok && !pend.valid) begin
                    pend_store = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        slot_req = '0;
        if ((state == ST_RD_REQ) || (state == ST_WR_REQ)) slot_req[slot_idx] = 1'b1;
        slot_we = (state == ST_WR_REQ);
        busy    = (state != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_cs     <= '0;
            slot_idx    <= '0;
            pend        <= '0;
            bus_rd_data <= '0;
            slot_wdata  <= '0;
            err_pulse   <= 1'b0;
            err_count   <= '0;
        end else begin
            prev_cs   <= bus_cs;
            err_pulse <= err_evt;
            if (slot_load) slot_idx <= slot_load_val;
            if (pend_clear) begin
                pend.valid <= 1'b0;
            end else if (pend_store) begin
                pend.valid   <= 1'b1;
                pend.is_read <= bus_state;
                pend.slot    <= FSMC_CS_WIDTH'(cs_idx);
            end
            if (state == ST_RD_REQ) begin
                if (ack_sel) bus_rd_data <= rdata_arr[slot_idx];
                else if (!cs_idle && to_expired) bus_rd_data <= DEFAULT_RD_DATA;
            end
            if ((state == ST_WR_ARM) && cs_idle) slot_wdata <= bus_data;
            if (err_evt && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_fsmc_slot_scheduler.sv
// tb/tb_fsmc_slot_scheduler.sv - self-checking bench for fsmc_slot_scheduler
module tb_fsmc_slot_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  bus_cs;
    logic        bus_state;
    logic [15:0] bus_data;
    logic [15:0] bus_rd_data;
    logic [3:0]  slot_req;
    logic        slot_we;
    logic [15:0] slot_wdata;
    logic [63:0] slot_rdata;
    logic [3:0]  slot_ack;
    logic        busy;
    logic        err_pulse;
    logic [7:0]  err_count;

    int tests_run;
    int tests_failed;

    fsmc_slot_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .bus_cs      (bus_cs),
        .bus_state   (bus_state),
        .bus_data    (bus_data),
        .bus_rd_data (bus_rd_data),
        .slot_req    (slot_req),
        .slot_we     (slot_we),
        .slot_wdata  (slot_wdata),
        .slot_rdata  (slot_rdata),
        .slot_ack    (slot_ack),
        .busy        (busy),
        .err_pulse   (err_pulse),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cs;
        logic        st;
        logic [15:0] data;
        logic [3:0]  ack;
        logic [3:0]  req;
        logic        we;
        logic        busy;
        logic        err;
        logic [15:0] rd;
        logic [7:0]  cnt;
        logic [15:0] wd;
    } vec_t;

    vec_t vecs[32];

    function automatic vec_t mk(input logic [3:0] cs, input logic st, input logic [15:0] data,
                                input logic [3:0] ack, input logic [3:0] req, input logic we,
                                input logic bsy, input logic err, input logic [15:0] rd,
                                input logic [7:0] cnt, input logic [15:0] wd);
        vec_t v;
        v.cs = cs; v.st = st; v.data = data; v.ack = ack; v.req = req; v.we = we;
        v.busy = bsy; v.err = err; v.rd = rd; v.cnt = cnt; v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cs, input logic st, input logic [15:0] data, input logic [3:0] ack);
        bus_cs = cs; bus_state = st; bus_data = data; slot_ack = ack;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        slot_rdata   = {16'hD333, 16'hC222, 16'h1234, 16'hA000};
        drive(4'h0, 1'b0, 16'h0, 4'h0);
        reset = 1'b1;
        step();
        step();
        chk("reset_req", slot_req, 4'h0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_rd", bus_rd_data, 16'h0);
        chk("reset_cnt", err_count, 8'h0);
        reset = 1'b0;

        //            cs    st    data      ack  | req   we    busy  err   rd        cnt    wdata
        vecs[0]  = mk(4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd0, 16'h0000);
        vecs[1]  = mk(4'h2, 1'b1, 16'h0000, 4'h0, 4'h2, 1'b0, 1'b1, 1'b0, 16'h0000, 8'd0, 16'h0000);
        vecs[2]  = mk(4'h2, 1'b1, 16'h0000, 4'h1, 4'h2, 1'b0, 1'b1, 1'b0, 16'h0000, 8'd0, 16'h0000);
        vecs[3]  = mk(4'h2, 1'b1, 16'h0000, 4'h0, 4'h2, 1'b0, 1'b1, 1'b0, 16'h0000, 8'd0, 16'h0000);
        vecs[4]  = mk(4'h2, 1'b1, 16'h0000, 4'h2, 4'h0, 1'b0, 1'b1, 1'b0, 16'h1234, 8'd0, 16'h0000);
        vecs[5]  = mk(4'h2, 1'b1, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h1234, 8'd0, 16'h0000);
        vecs[6]  = mk(4'h0, 1'b1, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h1234, 8'd0, 16'h0000);
        vecs[7]  = mk(4'h4, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h1234, 8'd0, 16'h0000);
        vecs[8]  = mk(4'h4, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h1234, 8'd0, 16'h0000);
        vecs[9]  = mk(4'h0, 1'b0, 16'hBEEF, 4'h0, 4'h4, 1'b1, 1'b1, 1'b0, 16'h1234, 8'd0, 16'hBEEF);
        vecs[10] = mk(4'h0, 1'b0, 16'h0000, 4'h0, 4'h4, 1'b1, 1'b1, 1'b0, 16'h1234, 8'd0, 16'hBEEF);
        vecs[11] = mk(4'h0, 1'b0, 16'h0000, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0, 16'h1234, 8'd0, 16'hBEEF);
        vecs[12] = mk(4'h3, 1'b1, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h1234, 8'd1, 16'hBEEF);
        vecs[13] = mk(4'h3, 1'b1, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h1234, 8'd1, 16'hBEEF);
        vecs[14] = mk(4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h1234, 8'd1, 16'hBEEF);
        vecs[15] = mk(4'h1, 1'b1, 16'h0000, 4'h0, 4'h1, 1'b0, 1'b1, 1'b0, 16'h1234, 8'd1, 16'hBEEF);
        vecs[16] = mk(4'h0, 1'b1, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h1234, 8'd2, 16'hBEEF);
        vecs[17] = mk(4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h1234, 8'd2, 16'hBEEF);
        vecs[18] = mk(4'h4, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h1234, 8'd2, 16'hBEEF);
        vecs[19] = mk(4'h0, 1'b0, 16'h5A5A, 4'h0, 4'h4, 1'b1, 1'b1, 1'b0, 16'h1234, 8'd2, 16'h5A5A);
        vecs[20] = mk(4'h1, 1'b1, 16'h0000, 4'h0, 4'h4, 1'b1, 1'b1, 1'b0, 16'h1234, 8'd2, 16'h5A5A);
        vecs[21] = mk(4'h1, 1'b1, 16'h0000, 4'h4, 4'h1, 1'b0, 1'b1, 1'b0, 16'h1234, 8'd2, 16'h5A5A);
        vecs[22] = mk(4'h1, 1'b1, 16'h0000, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0, 16'hA000, 8'd2, 16'h5A5A);
        vecs[23] = mk(4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA000, 8'd2, 16'h5A5A);
        vecs[24] = mk(4'h4, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'hA000, 8'd2, 16'h5A5A);
        vecs[25] = mk(4'h0, 1'b0, 16'h1111, 4'h0, 4'h4, 1'b1, 1'b1, 1'b0, 16'hA000, 8'd2, 16'h1111);
        vecs[26] = mk(4'h1, 1'b1, 16'h0000, 4'h0, 4'h4, 1'b1, 1'b1, 1'b0, 16'hA000, 8'd2, 16'h1111);
        vecs[27] = mk(4'h0, 1'b0, 16'h0000, 4'h0, 4'h4, 1'b1, 1'b1, 1'b0, 16'hA000, 8'd2, 16'h1111);
        vecs[28] = mk(4'h8, 1'b1, 16'h0000, 4'h0, 4'h4, 1'b1, 1'b1, 1'b1, 16'hA000, 8'd3, 16'h1111);
        vecs[29] = mk(4'h8, 1'b1, 16'h0000, 4'h4, 4'h1, 1'b0, 1'b1, 1'b0, 16'hA000, 8'd3, 16'h1111);
        vecs[30] = mk(4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 16'hA000, 8'd4, 16'h1111);
        vecs[31] = mk(4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA000, 8'd4, 16'h1111);

        for (int i = 0; i < 32; i++) begin
            drive(vecs[i].cs, vecs[i].st, vecs[i].data, vecs[i].ack);
            step();
            chk($sformatf("v%0d_req", i),   slot_req,    vecs[i].req);
            chk($sformatf("v%0d_we", i),    slot_we,     vecs[i].we);
            chk($sformatf("v%0d_busy", i),  busy,        vecs[i].busy);
            chk($sformatf("v%0d_err", i),   err_pulse,   vecs[i].err);
            chk($sformatf("v%0d_rd", i),    bus_rd_data, vecs[i].rd);
            chk($sformatf("v%0d_cnt", i),   err_count,   vecs[i].cnt);
            chk($sformatf("v%0d_wdata", i), slot_wdata,  vecs[i].wd);
        end

        // Read timeout on slot 3: 15 request cycles, then default data and one error.
        reset = 1'b1;
        drive(4'h0, 1'b0, 16'h0, 4'h0);
        step();
        reset = 1'b0;
        step();
        drive(4'h8, 1'b1, 16'h0, 4'h0);
        step();
        chk("to_start_req", slot_req, 4'h8);
        for (int i = 1; i <= 14; i++) begin
            step();
            chk($sformatf("to_wait%0d_req", i), slot_req, 4'h8);
            chk($sformatf("to_wait%0d_err", i), err_pulse, 1'b0);
        end
        step();
        chk("to_end_req", slot_req, 4'h0);
        chk("to_end_rd", bus_rd_data, 16'hDEAD);
        chk("to_end_err", err_pulse, 1'b1);
        chk("to_end_cnt", err_count, 8'd1);
        chk("to_end_busy", busy, 1'b1);
        step();
        chk("to_after_err", err_pulse, 1'b0);
        drive(4'h0, 1'b0, 16'h0, 4'h0);
        step();
        chk("to_idle_busy", busy, 1'b0);

        // Ack on the final allowed cycle wins over the timeout.
        drive(4'h2, 1'b1, 16'h0, 4'h0);
        step();
        for (int i = 1; i <= 14; i++) step();
        chk("race_pre_req", slot_req, 4'h2);
        slot_ack = 4'h2;
        step();
        slot_ack = 4'h0;
        chk("race_rd", bus_rd_data, 16'h1234);
        chk("race_err", err_pulse, 1'b0);
        chk("race_cnt", err_count, 8'd1);
        chk("race_req", slot_req, 4'h0);
        drive(4'h0, 1'b0, 16'h0, 4'h0);
        step();

        // Error counter saturates at 255.
        for (int i = 0; i < 260; i++) begin
            bus_cs = 4'h3;
            step();
            bus_cs = 4'h0;
            step();
        end
        chk("sat_cnt", err_count, 8'hFF);

        // Asynchronous reset in the middle of a write request.
        drive(4'h4, 1'b0, 16'h0, 4'h0);
        step();
        drive(4'h0, 1'b0, 16'h7777, 4'h0);
        step();
        chk("rst_pre_req", slot_req, 4'h4);
        chk("rst_pre_we", slot_we, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_async_req", slot_req, 4'h0);
        chk("rst_async_we", slot_we, 1'b0);
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_wdata", slot_wdata, 16'h0);
        chk("rst_async_rd", bus_rd_data, 16'h0);
        chk("rst_async_cnt", err_count, 8'h0);
        chk("rst_async_err", err_pulse, 1'b0);
        step();
        reset = 1'b0;
        step();
        chk("rst_no_resume_req", slot_req, 4'h0);
        chk("rst_no_resume_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fsmc_slot_scheduler.md
FSMC_SLOT_SCHEDULER -- requirements
Module: fsmc_slot_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, 16, data width of bus and slots; CS_WIDTH, 2, slot index width; NUM_SLOTS, 2**CS_WIDTH, peripheral slots.
REQ-002 Parameter TIMEOUT_CYCLES, 15, maximum request cycles before abort; DEFAULT_RD_DATA, 16'hDEAD, read data returned on timeout.
REQ-003 Ports SHALL be: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 bus_cs  input  NUM_SLOTS  one-hot slot select from the FSMC bridge.
REQ-007 bus_state  input  1  1 = read transaction, 0 = write; valid while bus_cs != 0.
REQ-008 bus_data  input  DATA_WIDTH  captured write data from the bridge; valid on the cycle bus_cs returns to 0.
REQ-009 bus_rd_data  output  DATA_WIDTH  read data driven back to the bridge.
REQ-010 slot_req  output  NUM_SLOTS  one-hot level request to the selected slot.
REQ-011 slot_we  output  1  1 = write request, 0 = read request.
REQ-012 slot_wdata  output  DATA_WIDTH  write data to the slot, stable while slot_req != 0.
REQ-013 slot_rdata  input  NUM_SLOTS*DATA_WIDTH  packed slot read data; slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 slot_ack  input  NUM_SLOTS  one-cycle completion pulse per slot.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 err_pulse  output  1  one-cycle pulse on timeout, abort or illegal select.
REQ-017 err_count  output  8  saturating error counter.

Function
REQ-018 The FSM SHALL have states IDLE, RD_REQ, HOLD, WR_ARM, WR_REQ.
REQ-019 Start: in IDLE, a cycle with registered previous bus_cs == 0 and one-hot bus_cs SHALL latch the slot index and move to RD_REQ (bus_state=1) or WR_ARM (bus_state=0).
REQ-020 Non-one-hot nonzero bus_cs at a start SHALL be ignored, pulse err_pulse and increment err_count.
REQ-021 RD_REQ: slot_req[slot]=1, slot_we=0; on slot_ack[slot], bus_rd_data SHALL take that slot's rdata on the next edge and the FSM SHALL enter HOLD.
REQ-022 RD_REQ timeout: after TIMEOUT_CYCLES cycles without ack, bus_rd_data SHALL take DEFAULT_RD_DATA, err_pulse fires, and the FSM enters HOLD.
REQ-023 Ack and timeout in the same cycle: ack wins, no error.
REQ-024 RD_REQ with bus_cs falling to 0 before ack: drop slot_req, return to IDLE, signal error (abort).
REQ-025 HOLD: bus_rd_data stable; on bus_cs == 0, return to IDLE.
REQ-026 WR_ARM: on bus_cs == 0, latch bus_data into slot_wdata and enter WR_REQ; no slot_req while armed.
REQ-027 WR_REQ: slot_req[slot]=1, slot_we=1; ack or timeout (with error) SHALL end the request.
REQ-028 A start event during WR_REQ SHALL be stored in a one-entry pending register (slot, direction), consumed immediately after WR_REQ ends instead of returning to IDLE; a second start while pending is full SHALL be dropped with an error.
REQ-029 The timeout counter SHALL clear on each entry to RD_REQ/WR_REQ and count cycles in them.
REQ-030 err_count SHALL saturate at 255.
REQ-031 Acks from non-selected slots SHALL be ignored.

Reset
REQ-032 Reset SHALL force IDLE and clear slot_req, slot_we, slot_wdata, busy, err_pulse, err_count, the pending entry and the timeout counter; bus_rd_data SHALL reset to 0.
REQ-033 Reset mid-request SHALL drop slot_req asynchronously; there is no resume.

Structure
REQ-034 The package fsmc_pkg SHALL hold the state enum, the DEFAULT_RD_DATA and TIMEOUT_CYCLES defaults, and the pending-entry struct.
REQ-035 One sub-module, fsmc_timeout_ctr (clear/enable/expired), SHALL be used; all other logic is flat.

Verification
REQ-036 Read: bus_cs=4'b0010, state=1; slot1 acks after 3 cycles with 16'h1234 -> slot_req=4'b0010, bus_rd_data=16'h1234, HOLD until cs=0.
REQ-037 Write: bus_cs=4'b0100, state=0, cs drops with bus_data=16'hBEEF -> slot_req=4'b0100, slot_we=1, slot_wdata=16'hBEEF until ack.
REQ-038 Timeout: read to slot3 with no ack -> after 15 cycles bus_rd_data=16'hDEAD, err_pulse once, err_count=1.
REQ-039 Back-to-back: read start to slot0 during WR_REQ to slot2 -> RD_REQ slot0 directly after slot2 ack, with no IDLE cycle.
REQ-040 Illegal select and abort: bus_cs=4'b0011 -> no slot_req, err_count+1; cs drops during RD_REQ -> slot_req cleared next cycle, err_count+1.
REQ-041 Reset asserted during WR_REQ -> slot_req=0 immediately and all outputs at reset values.
